cdb_arbiter: RTL and testbench



---
 rtl/cdb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one registered Common Data Bus among NUM_FU functional units.
//
// Each FU result is captured into a one-entry holding buffer. Every cycle one buffered
// result is picked (round-robin starting at rr_ptr) and registered onto the CDB.
// A buffer that is being granted can take a new result on the same edge.
//
// Build option: define CDB_FIXED_PRIORITY_EN to replace round-robin with fixed
// lowest-index-wins priority (rr_ptr is removed). Ports and latency are unchanged.
//
// Ports:
//   clock, reset_n      clock and asynchronous active-low reset
//   fu_valid/tag/value  per-FU result offer (slice i belongs to FU i)
//   fu_ready            per-FU buffer can accept this cycle (not a function of fu_valid)
//   flush               squash all buffered results and the next CDB beat
//   cdb_valid/tag/value registered CDB broadcast
//   cdb_grant           one-hot source FU of the current CDB beat, 0 when idle
module cdb_arbiter #(
    parameter int unsigned NUM_FU = 4,
    parameter int unsigned TAG_W  = 2,
    parameter int unsigned XLEN   = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU*TAG_W-1:0] fu_tag,
    input  logic [NUM_FU*XLEN-1:0]  fu_value,
    output logic [NUM_FU-1:0]       fu_ready,
    input  logic                    flush,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [XLEN-1:0]         cdb_value,
    output logic [NUM_FU-1:0]       cdb_grant
);

    localparam int unsigned IdxW = $clog2(NUM_FU);

    logic [NUM_FU-1:0]            buf_valid_q, buf_valid_d;
    logic [NUM_FU-1:0][TAG_W-1:0] buf_tag_q, buf_tag_d;
    logic [NUM_FU-1:0][XLEN-1:0]  buf_value_q, buf_value_d;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]   cdb_value_q, cdb_value_d;
    logic [NUM_FU-1:0] cdb_grant_q, cdb_grant_d;

    logic [NUM_FU-1:0] win;
    logic [IdxW-1:0]   win_idx;
    logic              broadcast;

`ifdef CDB_FIXED_PRIORITY_EN
    // Scan from the top so the lowest valid index is the last (winning) assignment.
    always_comb begin
        win     = '0;
        win_idx = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (buf_valid_q[i]) begin
                win     = '0;
                win[i]  = 1'b1;
                win_idx = IdxW'(i);
            end
        end
    end
`else
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW:0]   scan_idx;
    logic [IdxW:0]   rr_next;

    // Scan offsets from farthest to nearest so the buffer closest to rr_ptr wins.
    always_comb begin
        win      = '0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr_q} + (IdxW + 1)'(k);
            if (scan_idx >= (IdxW + 1)'(NUM_FU)) begin
                scan_idx = scan_idx - (IdxW + 1)'(NUM_FU);
            end
            if (buf_valid_q[scan_idx[IdxW-1:0]]) begin
                win                      = '0;
                win[scan_idx[IdxW-1:0]]  = 1'b1;
                win_idx                  = scan_idx[IdxW-1:0];
            end
        end
    end

    always_comb begin
        rr_next = {1'b0, win_idx} + (IdxW + 1)'(1);
        if (rr_next >= (IdxW + 1)'(NUM_FU)) begin
            rr_next = '0;
        end
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (|win) begin
            rr_ptr_d = rr_next[IdxW-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // A granted buffer frees up on this edge, so it may be refilled at the same time.
    assign fu_ready  = ~buf_valid_q | win;
    assign broadcast = (|win) && !flush;

    always_comb begin
        buf_valid_d = buf_valid_q & ~win;
        buf_tag_d   = buf_tag_q;
        buf_value_d = buf_value_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i] && !flush) begin
                buf_valid_d[i] = 1'b1;
                buf_tag_d[i]   = fu_tag[i*TAG_W +: TAG_W];
                buf_value_d[i] = fu_value[i*XLEN +: XLEN];
            end
        end
        if (flush) begin
            buf_valid_d = '0;
        end

        cdb_valid_d = broadcast;
        cdb_grant_d = broadcast ? win : '0;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        if (broadcast) begin
            cdb_tag_d   = buf_tag_q[win_idx];
            cdb_value_d = buf_value_q[win_idx];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid_q <= '0;
            buf_tag_q   <= '0;
            buf_value_q <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_grant_q <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_value_q <= buf_value_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_grant_q <= cdb_grant_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;
    assign cdb_grant = cdb_grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (default round-robin build, NUM_FU=4).
// Expected CDB beats are queued as stimulus is driven; a negedge monitor pops and
// compares each broadcast. Cycle-exact latency/ready checks are made inline.
module tb_cdb_arbiter;

    localparam int unsigned NUM_FU = 4;
    localparam int unsigned TAG_W  = 2;
    localparam int unsigned XLEN   = 32;

    logic                    clock;
    logic                    reset_n;
    logic [NUM_FU-1:0]       fu_valid;
    logic [NUM_FU*TAG_W-1:0] fu_tag;
    logic [NUM_FU*XLEN-1:0]  fu_value;
    logic [NUM_FU-1:0]       fu_ready;
    logic                    flush;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [XLEN-1:0]         cdb_value;
    logic [NUM_FU-1:0]       cdb_grant;

    cdb_arbiter #(
        .NUM_FU (NUM_FU),
        .TAG_W  (TAG_W),
        .XLEN   (XLEN)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_value  (fu_value),
        .fu_ready  (fu_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_grant (cdb_grant)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [XLEN-1:0]   value;
        logic [NUM_FU-1:0] grant;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_fu(input int fu, input int tag, input int val);
        fu_valid[fu]                = 1'b1;
        fu_tag[fu*TAG_W +: TAG_W]   = TAG_W'(tag);
        fu_value[fu*XLEN +: XLEN]   = XLEN'(val);
    endtask

    task automatic push(input int fu, input int tag, input int val);
        exp_t e;
        e.tag   = TAG_W'(tag);
        e.value = XLEN'(val);
        e.grant = NUM_FU'(1) << fu;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    // Scoreboard monitor: every broadcast must match the next queued beat.
    always @(negedge clock) begin
        if (reset_n) begin
            if (cdb_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {cdb_grant, cdb_tag}, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_tag", 64'(cdb_tag), 64'(e.tag));
                    check("sb_value", 64'(cdb_value), 64'(e.value));
                    check("sb_grant", 64'(cdb_grant), 64'(e.grant));
                end
            end else begin
                check("idle_grant", 64'(cdb_grant), 64'd0);
            end
        end
    end

    initial begin
        logic [NUM_FU-1:0] exp_rdy;
        int a;
        int b;
        reset_n  = 1'b0;
        fu_valid = '0;
        fu_tag   = '0;
        fu_value = '0;
        flush    = 1'b0;

        // Reset then idle
        #1;
        check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        check("rst_cdb_grant", 64'(cdb_grant), 64'd0);
        #11 reset_n = 1'b1;
        tick();
        check("idle_ready", 64'(fu_ready), 64'hf);
        check("idle_valid", 64'(cdb_valid), 64'd0);
        tick();
        check("idle_valid2", 64'(cdb_valid), 64'd0);

        // Single result: t -> t+2 latency
        set_fu(2, 3, 5);
        push(2, 3, 5);
        tick();
        fu_valid = '0;
        check("single_t1_valid", 64'(cdb_valid), 64'd0);
        check("single_t1_ready", 64'(fu_ready), 64'hf);
        tick();
        check("single_t2_valid", 64'(cdb_valid), 64'd1);
        check("single_t2_tag", 64'(cdb_tag), 64'd3);
        check("single_t2_value", 64'(cdb_value), 64'd5);
        check("single_t2_grant", 64'(cdb_grant), 64'b0100);
        tick();
        check("single_t3_valid", 64'(cdb_valid), 64'd0);
        check("single_t3_hold_tag", 64'(cdb_tag), 64'd3);

        // Asynchronous reset mid-cycle while the CDB is busy
        set_fu(1, 1, 77);
        push(1, 1, 77);
        tick();
        fu_valid = '0;
        tick();
        check("arst_pre_valid", 64'(cdb_valid), 64'd1);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(cdb_valid), 64'd0);
        check("arst_grant", 64'(cdb_grant), 64'd0);
        check("arst_value", 64'(cdb_value), 64'd0);
        #1 reset_n = 1'b1;
        tick();

        // Contention: all four at once, rr_ptr=0 -> tags 0,1,2,3
        for (int i = 0; i < 4; i++) begin
            set_fu(i, i, 10 + i);
            push(i, i, 10 + i);
        end
        tick();
        fu_valid = '0;
        check("cont_ready_t1", 64'(fu_ready), 64'b0001);
        tick();
        check("cont_tag0", 64'(cdb_tag), 64'd0);
        check("cont_ready_t2", 64'(fu_ready), 64'b0011);
        tick();
        check("cont_tag1", 64'(cdb_tag), 64'd1);
        check("cont_ready_t3", 64'(fu_ready), 64'b0111);
        tick();
        check("cont_tag2", 64'(cdb_tag), 64'd2);
        tick();
        check("cont_tag3", 64'(cdb_tag), 64'd3);
        tick();
        check("cont_end_valid", 64'(cdb_valid), 64'd0);
        drain();

        // Fairness: FU0 and FU2 offer every cycle for 8 cycles; FU holds until accepted
        a = 0;
        b = 0;
        for (int k = 0; k < 4; k++) begin
            push(0, k, 100 + k);
            push(2, k, 200 + k);
        end
        push(0, 4, 104);
        for (int c = 1; c <= 8; c++) begin
            fu_valid = '0;
            set_fu(0, a, 100 + a);
            set_fu(2, b, 200 + b);
            exp_rdy = (c == 1) ? 4'b1111 : ((c % 2 == 0) ? 4'b1011 : 4'b1110);
            check("fair_ready", 64'(fu_ready), 64'(exp_rdy));
            if (exp_rdy[0]) a++;
            if (exp_rdy[2]) b++;
            tick();
        end
        fu_valid = '0;
        drain();

        // Drain and refill FU1 on the same edge (rr_ptr=1 here)
        set_fu(1, 1, 300);
        push(1, 1, 300);
        push(1, 2, 301);
        tick();
        set_fu(1, 2, 301);
        check("refill_ready_t", 64'(fu_ready), 64'hf);
        tick();
        fu_valid = '0;
        check("refill_tag_a", 64'(cdb_tag), 64'd1);
        check("refill_value_a", 64'(cdb_value), 64'd300);
        tick();
        check("refill_valid_b", 64'(cdb_valid), 64'd1);
        check("refill_value_b", 64'(cdb_value), 64'd301);
        drain();

        // Flush with buffers 0 and 3 occupied and a beat on the CDB
        set_fu(1, 0, 401);
        push(1, 0, 401);
        tick();
        fu_valid = '0;
        set_fu(0, 1, 400);
        set_fu(3, 3, 403);
        tick();
        fu_valid = '0;
        check("flush_pre_valid", 64'(cdb_valid), 64'd1);
        set_fu(2, 2, 402);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        fu_valid = '0;
        check("flush_valid", 64'(cdb_valid), 64'd0);
        check("flush_grant", 64'(cdb_grant), 64'd0);
        check("flush_ready", 64'(fu_ready), 64'hf);
        tick();
        check("flush_valid2", 64'(cdb_valid), 64'd0);
        // rr_ptr back to 0: FU1 must win over FU3
        set_fu(1, 1, 501);
        set_fu(3, 3, 503);
        push(1, 1, 501);
        push(3, 3, 503);
        tick();
        fu_valid = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
